ex_mem_stage_reg: RTL and testbench

EX/MEM pipeline register for the 5-stage MIPS datapath. Captures the Execute-stage results (ALU result, branch target, zero flag, store data, control bits) and the 5-bit destination register chosen by the Execute destination mux. Presents them to the Memory stage through a valid/ready handshake. A 2-entry skid buffer keeps throughput at one instruction per cycle under downstream stalls without a combinational ready path; a synchronous flush turns held entries into bubbles on branch redirect.

---
 rtl/ex_mem_stage_reg.sv | 102 ++++++++++
 tb/tb_ex_mem_stage_reg.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/ex_mem_stage_reg.sv
// EX/MEM pipeline register with a 2-entry skid buffer and valid/ready handshake.
// in_ready is registered state (NOT skid valid), so out_ready never reaches it combinationally.
module ex_mem_stage_reg #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  input  logic [1:0]        wb_ctl_in,
  input  logic [2:0]        m_ctl_in,
  input  logic [DATA_W-1:0] add_result_in,
  input  logic              alu_zero_in,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic [DATA_W-1:0] rdata2_in,
  input  logic [REG_W-1:0]  wreg_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        wb_ctl_out,
  output logic [2:0]        m_ctl_out,
  output logic [DATA_W-1:0] add_result_out,
  output logic              alu_zero_out,
  output logic [DATA_W-1:0] alu_result_out,
  output logic [DATA_W-1:0] rdata2_out,
  output logic [REG_W-1:0]  wreg_out,
  output logic              pcsrc_out
);

  typedef struct packed {
    logic [1:0]        wb;
    logic [2:0]        m;
    logic [DATA_W-1:0] add;
    logic              zero;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] rd2;
    logic [REG_W-1:0]  wreg;
  } entry_t;

  entry_t main_q, main_d, skid_q, skid_d, in_e;
  logic   main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
  logic   accept;

  assign in_e = '{wb: wb_ctl_in, m: m_ctl_in, add: add_result_in, zero: alu_zero_in,
                  alu: alu_result_in, rd2: rdata2_in, wreg: wreg_in};

  assign in_ready = ~skid_vld_q;
  assign accept   = in_valid & ~skid_vld_q;

  always_comb begin
    main_d     = main_q;
    skid_d     = skid_q;
    main_vld_d = main_vld_q;
    skid_vld_d = skid_vld_q;
    if (flush) begin
      // Data fields keep their last value; only the valid bits are dropped.
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (!main_vld_q || out_ready) begin
      if (skid_vld_q) begin
        main_d     = skid_q;
        main_vld_d = 1'b1;
        skid_vld_d = 1'b0;
      end else if (accept) begin
        main_d     = in_e;
        main_vld_d = 1'b1;
      end else begin
        main_vld_d = 1'b0;
      end
    end else if (accept) begin
      skid_d     = in_e;
      skid_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
    end
  end

  // Control fields read as a bubble whenever the main entry is empty.
  assign out_valid      = main_vld_q;
  assign wb_ctl_out     = main_vld_q ? main_q.wb : 2'b00;
  assign m_ctl_out      = main_vld_q ? main_q.m  : 3'b000;
  assign add_result_out = main_q.add;
  assign alu_zero_out   = main_q.zero;
  assign alu_result_out = main_q.alu;
  assign rdata2_out     = main_q.rd2;
  assign wreg_out       = main_q.wreg;
  assign pcsrc_out      = main_q.m[2] & main_q.zero & main_vld_q;

endmodule

// File: tb/tb_ex_mem_stage_reg.sv
// Bench for ex_mem_stage_reg: directed vector table, async-reset sequence,
// then random traffic against a queue-based FIFO reference model.
module tb_ex_mem_stage_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, flush, out_valid, out_ready;
  logic [1:0]  wb_ctl_in, wb_ctl_out;
  logic [2:0]  m_ctl_in, m_ctl_out;
  logic [31:0] add_result_in, add_result_out, alu_result_in, alu_result_out;
  logic [31:0] rdata2_in, rdata2_out;
  logic        alu_zero_in, alu_zero_out, pcsrc_out;
  logic [4:0]  wreg_in, wreg_out;

  int checks = 0;
  int failures = 0;

  ex_mem_stage_reg #(.DATA_W(32), .REG_W(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .wb_ctl_in(wb_ctl_in), .m_ctl_in(m_ctl_in), .add_result_in(add_result_in),
    .alu_zero_in(alu_zero_in), .alu_result_in(alu_result_in), .rdata2_in(rdata2_in),
    .wreg_in(wreg_in), .out_valid(out_valid), .out_ready(out_ready),
    .wb_ctl_out(wb_ctl_out), .m_ctl_out(m_ctl_out), .add_result_out(add_result_out),
    .alu_zero_out(alu_zero_out), .alu_result_out(alu_result_out),
    .rdata2_out(rdata2_out), .wreg_out(wreg_out), .pcsrc_out(pcsrc_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic iv, ordy, fl;
    logic [4:0] w; logic [1:0] wb; logic [2:0] m; logic z;
    logic [31:0] add, alu;
    logic eov, eir; logic [4:0] ew; logic [1:0] ewb; logic epc;
    logic [31:0] ealu, eadd;
  } vec_t;

  typedef struct packed {
    logic [1:0] wb; logic [2:0] m; logic [31:0] add; logic z;
    logic [31:0] alu; logic [31:0] rd2; logic [4:0] wreg;
  } ent_t;

  function automatic vec_t v(logic iv, logic ordy, logic fl, logic [4:0] w, logic [1:0] wb,
                             logic [2:0] m, logic z, logic [31:0] add, logic [31:0] alu,
                             logic eov, logic eir, logic [4:0] ew, logic [1:0] ewb,
                             logic epc, logic [31:0] ealu, logic [31:0] eadd);
    vec_t r;
    r.iv = iv; r.ordy = ordy; r.fl = fl; r.w = w; r.wb = wb; r.m = m; r.z = z;
    r.add = add; r.alu = alu; r.eov = eov; r.eir = eir; r.ew = ew; r.ewb = ewb;
    r.epc = epc; r.ealu = ealu; r.eadd = eadd;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic iv, input logic ordy, input logic fl, input ent_t e);
    in_valid = iv; out_ready = ordy; flush = fl;
    wb_ctl_in = e.wb; m_ctl_in = e.m; add_result_in = e.add; alu_zero_in = e.z;
    alu_result_in = e.alu; rdata2_in = e.rd2; wreg_in = e.wreg;
  endtask

  vec_t tbl[22];
  ent_t q[$];
  ent_t last, e;
  logic mir, acc, drn, ev;

  initial begin
    // Directed table: test-plan scenarios with hand-derived post-edge outputs.
    tbl[0]  = v(1,1,0, 9,2'b10,3'b000,0,32'h24,32'h10,  1,1, 9,2'b10,0,32'h10,32'h24);
    tbl[1]  = v(0,1,0, 0,2'b00,3'b000,0,0,0,            0,1, 9,2'b00,0,32'h10,32'h24);
    tbl[2]  = v(1,1,0, 1,2'b10,3'b000,0,4,16,           1,1, 1,2'b10,0,16,4);
    tbl[3]  = v(1,1,0, 2,2'b10,3'b000,0,8,32,           1,1, 2,2'b10,0,32,8);
    tbl[4]  = v(1,1,0, 3,2'b10,3'b000,0,12,48,          1,1, 3,2'b10,0,48,12);
    tbl[5]  = v(1,1,0, 4,2'b10,3'b000,0,16,64,          1,1, 4,2'b10,0,64,16);
    tbl[6]  = v(0,1,0, 0,2'b00,3'b000,0,0,0,            0,1, 4,2'b00,0,64,16);
    tbl[7]  = v(1,1,0,11,2'b01,3'b000,0,44,176,         1,1,11,2'b01,0,176,44);
    tbl[8]  = v(1,0,0,12,2'b01,3'b000,0,48,192,         1,0,11,2'b01,0,176,44);
    tbl[9]  = v(1,0,0,13,2'b01,3'b000,0,52,208,         1,0,11,2'b01,0,176,44);
    tbl[10] = v(1,0,0,13,2'b01,3'b000,0,52,208,         1,0,11,2'b01,0,176,44);
    tbl[11] = v(1,1,0,13,2'b01,3'b000,0,52,208,         1,1,12,2'b01,0,192,48);
    tbl[12] = v(1,1,0,13,2'b01,3'b000,0,52,208,         1,1,13,2'b01,0,208,52);
    tbl[13] = v(1,1,0,14,2'b01,3'b000,0,56,224,         1,1,14,2'b01,0,224,56);
    tbl[14] = v(0,1,0, 0,2'b00,3'b000,0,0,0,            0,1,14,2'b00,0,224,56);
    tbl[15] = v(1,1,0, 7,2'b00,3'b100,1,32'h40,112,     1,1, 7,2'b00,1,112,32'h40);
    tbl[16] = v(1,1,0, 8,2'b00,3'b100,0,32'h44,128,     1,1, 8,2'b00,0,128,32'h44);
    tbl[17] = v(0,1,0, 0,2'b00,3'b000,0,0,0,            0,1, 8,2'b00,0,128,32'h44);
    tbl[18] = v(1,0,0,21,2'b11,3'b100,1,84,336,         1,1,21,2'b11,1,336,84);
    tbl[19] = v(1,0,0,22,2'b11,3'b100,1,88,352,         1,0,21,2'b11,1,336,84);
    tbl[20] = v(1,0,1,23,2'b11,3'b100,1,92,368,         0,1,21,2'b00,0,336,84);
    tbl[21] = v(0,1,0, 0,2'b00,3'b000,0,0,0,            0,1,21,2'b00,0,336,84);

    rst = 1'b1;
    e = '{wb: 2'b11, m: 3'b111, add: 32'hFFFF_FFFF, z: 1'b1, alu: 32'hAAAA_AAAA,
          rd2: 32'h5555_5555, wreg: 5'd31};
    drive(1, 1, 0, e);
    @(posedge clk); #1;
    chk("reset_ctl", {out_valid, in_ready, pcsrc_out, wb_ctl_out, m_ctl_out, alu_zero_out, wreg_out},
        {1'b0, 1'b1, 1'b0, 2'b00, 3'b000, 1'b0, 5'd0});
    chk("reset_data", {add_result_out, alu_result_out, rdata2_out}, 96'd0);
    e = '0;
    drive(0, 1, 0, e);
    #2 rst = 1'b0;

    for (int i = 0; i < 22; i++) begin
      e = '{wb: tbl[i].wb, m: tbl[i].m, add: tbl[i].add, z: tbl[i].z, alu: tbl[i].alu,
            rd2: ~tbl[i].alu, wreg: tbl[i].w};
      drive(tbl[i].iv, tbl[i].ordy, tbl[i].fl, e);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_ctl", i), {out_valid, in_ready, wreg_out, wb_ctl_out, pcsrc_out},
          {tbl[i].eov, tbl[i].eir, tbl[i].ew, tbl[i].ewb, tbl[i].epc});
      chk($sformatf("vec%0d_data", i), {alu_result_out, add_result_out, rdata2_out},
          {tbl[i].ealu, tbl[i].eadd, ~tbl[i].ealu});
      if (!tbl[i].eov) chk($sformatf("vec%0d_mbubble", i), {29'd0, m_ctl_out}, 32'd0);
    end

    // Async reset pulsed between edges with both entries held.
    e = '{wb: 2'b10, m: 3'b100, add: 32'h80, z: 1'b1, alu: 32'h123, rd2: 32'h456, wreg: 5'd5};
    drive(1, 0, 0, e);
    @(posedge clk); #1;
    e.wreg = 5'd6;
    drive(1, 0, 0, e);
    @(posedge clk); #1;
    chk("pre_areset", {out_valid, in_ready, pcsrc_out, wreg_out}, {1'b1, 1'b0, 1'b1, 5'd5});
    #2 rst = 1'b1;
    #1;
    chk("areset_ctl", {out_valid, in_ready, pcsrc_out, wb_ctl_out, m_ctl_out, alu_zero_out, wreg_out},
        {1'b0, 1'b1, 1'b0, 2'b00, 3'b000, 1'b0, 5'd0});
    chk("areset_data", {add_result_out, alu_result_out, rdata2_out}, 96'd0);
    @(posedge clk); #1;
    chk("areset_hold", {out_valid, wreg_out, add_result_out}, {1'b0, 5'd0, 32'd0});
    e = '0;
    drive(0, 1, 0, e);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    chk("after_areset", {out_valid, in_ready}, {1'b0, 1'b1});

    // Random traffic against an ordered FIFO of capacity 2.
    q.delete();
    last = '0;
    for (int c = 0; c < 3000; c++) begin
      e = '{wb: 2'($urandom), m: 3'($urandom), add: $urandom, z: 1'($urandom),
            alu: $urandom, rd2: $urandom, wreg: 5'($urandom)};
      drive(1'($urandom), ($urandom_range(0, 9) < 6), ($urandom_range(0, 24) == 0), e);
      mir = (q.size() < 2);
      acc = in_valid && mir;
      drn = (q.size() > 0) && out_ready;
      @(posedge clk); #1;
      if (flush) q.delete();
      else begin
        if (drn) void'(q.pop_front());
        if (acc) q.push_back(e);
      end
      if (q.size() > 0) last = q[0];
      ev = (q.size() > 0);
      chk("rnd_ctl", {out_valid, in_ready, pcsrc_out, wb_ctl_out, m_ctl_out, alu_zero_out, wreg_out},
          {ev, q.size() < 2, ev & last.m[2] & last.z, ev ? last.wb : 2'b00,
           ev ? last.m : 3'b000, last.z, last.wreg});
      chk("rnd_data", {add_result_out, alu_result_out, rdata2_out}, {last.add, last.alu, last.rd2});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
